lsu_bus_arbiter: RTL and testbench
==================================

Name: lsu_bus_arbiter

Overview:
- Shares the single data bus between two requesters: the store buffer drain (writes of committed stores) and the execute_lsu load path (reads).
- One bus transaction at a time.
- Variable-latency bus using a req/ack handshake.
- Load priority with a starvation guard for stores; commit flush discards an in-flight load's response.
- Sits between store_buffer / execute_lsu and the bus interface.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width
SIZE_WIDTH, 2, access size code (0=byte, 1=half, 2=word)
STARVE_LIMIT, 4, consecutive load wins over a waiting store before the store is forced (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stbuf_req  in  1  store buffer has a write pending; held until stbuf_done
stbuf_addr  in  ADDR_WIDTH  write address
stbuf_size  in  SIZE_WIDTH  write size
stbuf_data  in  DATA_WIDTH  write data
stbuf_done  out  1  one-cycle pulse: write acknowledged by bus
ld_req  in  1  load pending; held until ld_valid or flush
ld_addr  in  ADDR_WIDTH  load address
ld_size  in  SIZE_WIDTH  load size
ld_valid  out  1  one-cycle pulse: ld_data valid
ld_data  out  DATA_WIDTH  raw bus read data (no extension)
flush  in  1  pipeline flush (commit_feedback_pack.flush)
bus_req  out  1  transaction request
bus_we  out  1  1=write, 0=read
bus_addr  out  ADDR_WIDTH  transaction address
bus_size  out  SIZE_WIDTH  transaction size
bus_wdata  out  DATA_WIDTH  write data
bus_ack  in  1  transaction complete; sampled only while bus_req=1
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack on reads

Behaviour:
- States:
  - IDLE
  - ST_BUSY: write in flight
  - LD_BUSY: read in flight
  - LD_DISCARD: read in flight, response dropped
- Reset (rst=0, asynchronous):
  - State goes to IDLE; starve_cnt=0.
  - All outputs 0, including bus_req, bus_we, bus_addr, bus_size, bus_wdata, stbuf_done, ld_valid and ld_data.
  - A bus transaction in progress at reset is abandoned.
- All outputs are registered.
- IDLE arbitration:
  - Eligible requesters are evaluated each cycle.
  - A requester whose done/valid pulse is high in this cycle is ineligible.
  - ld_req is ineligible when flush=1.
  - Only one eligible: it wins.
  - Both eligible: load wins unless starve_cnt >= STARVE_LIMIT, in which case the store wins.
- On a win, at the next edge:
  - The bus_* fields are latched from the winner.
  - bus_req=1.
  - State goes to ST_BUSY or LD_BUSY.
- bus_addr, bus_size, bus_wdata and bus_we are held stable while bus_req=1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when a load wins while stbuf_req=1.
  - Clears when a store wins or when stbuf_req=0 in IDLE.
- ST_BUSY: on bus_ack, at the edge:
  - bus_req=0, state goes to IDLE.
  - stbuf_done=1 for exactly one cycle.
  - Flush has no effect on ST_BUSY; committed stores always complete.
- LD_BUSY:
  - On bus_ack without flush: bus_req=0, ld_data<=bus_rdata, ld_valid=1 for one cycle, state goes to IDLE.
  - On flush without bus_ack: state goes to LD_DISCARD. bus_req stays 1 because a bus transaction is never aborted.
  - On flush and bus_ack in the same cycle: state goes to IDLE, bus_req=0, ld_valid stays 0, ld_data unchanged.
- LD_DISCARD: on bus_ack, state goes to IDLE, bus_req=0, no ld_valid. Further flushes are ignored.
- Minimum latency, request to completion pulse, is 2 cycles:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: bus_req=1, bus_ack=1.
  - Cycle 2: done/valid=1, back in IDLE.
- In the cycle 2 IDLE, the *other* requester may win, giving back-to-back alternation with no bubble.
- ld_data holds its last value when ld_valid=0.
- bus_ack while bus_req=0 is ignored.
- Requests arriving during a busy state are not queued internally; requesters hold req until served.

Test Plan:
- Reset mid-transaction: store in ST_BUSY with bus_ack=0, then rst=0 -> asynchronously, before the next edge, bus_req=0 and stbuf_done=0; after release, state is IDLE and a new request takes 2 cycles.
- Single store: stbuf_req=1, addr=0xaaccbeef, size=1, data=0x0000beef; bus_ack 3 cycles after bus_req rises -> bus_we=1 and fields stable for 3 cycles; stbuf_done pulses once the cycle after ack.
- Single load, zero wait: ld_req=1, addr=0x100, size=2; bus_ack in the same cycle bus_req=1 with rdata=0xdace1557 -> next cycle ld_valid=1, ld_data=0xdace1557, bus_req=0.
- Starvation, STARVE_LIMIT=4: stbuf_req and ld_req both held high, each ack immediate -> 4 loads are served, then 1 store, then counter cleared and loads resume; stbuf_done occurs exactly once per 5 transactions.
- Flush during load: ld_req served, flush=1 for one cycle while in LD_BUSY, ack 2 cycles later -> bus_req held until ack; ld_valid never asserts; state returns to IDLE.
- Flush with pending store and load in IDLE: flush=1, both req -> store wins regardless of starve_cnt; with flush+ack simultaneous in LD_BUSY -> no ld_valid.

Source files
------------

// File: rtl/lsu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_bus_arbiter
//
// Shares the single data bus between the store buffer drain (writes of
// committed stores) and the execute_lsu load path (reads). Exactly one bus
// transaction is outstanding at a time.
//
// Arbitration happens only in IDLE. Loads have priority. A store that has
// watched STARVE_LIMIT consecutive loads win while it was waiting is forced
// through on the next arbitration. A pipeline flush blocks a new load from
// winning, and turns an in-flight read into a discarded one. The read still
// runs to completion on the bus, but its data is never presented.
//
// Handshakes:
//   Requester side: stbuf_req / ld_req are levels held by the requester until
//   it sees its completion pulse (stbuf_done / ld_valid); a load may also be
//   dropped by flush. Nothing is queued here. In the cycle a pulse is high
//   the matching requester is ineligible, so a held-high req is taken as a
//   new request one cycle later.
//   Bus side: bus_req rises with bus_we/addr/size/wdata, and all of them
//   stay stable until the bus returns bus_ack (any number of cycles later,
//   including the first cycle bus_req is high). The transaction ends at the
//   edge that samples bus_ack=1. bus_ack is ignored while bus_req=0, and a
//   transaction, once issued, is never withdrawn.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   stbuf_req/addr/size/data, stbuf_done   store buffer write channel
//   ld_req/addr/size, ld_valid, ld_data    load read channel
//   flush                 pipeline flush from commit
//   bus_req/we/addr/size/wdata, bus_ack, bus_rdata   shared bus
//   state_dbg             current FSM state (IDLE=0, ST_BUSY=1, LD_BUSY=2,
//                         LD_DISCARD=3)
// ---------------------------------------------------------------------------
module lsu_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  stbuf_req,
  input  logic [ADDR_WIDTH-1:0] stbuf_addr,
  input  logic [SIZE_WIDTH-1:0] stbuf_size,
  input  logic [DATA_WIDTH-1:0] stbuf_data,
  output logic                  stbuf_done,

  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [SIZE_WIDTH-1:0] ld_size,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,

  input  logic                  flush,

  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [SIZE_WIDTH-1:0] bus_size,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,

  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ST_BUSY    = 2'd1,
    LD_BUSY    = 2'd2,
    LD_DISCARD = 2'd3
  } state_t;

  // Counter only needs to reach STARVE_LIMIT (it saturates there).
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic st_elig;
  logic ld_elig;
  logic starved;
  logic store_win;
  logic load_win;

  // Arbitration. The done/valid pulses are registered outputs, so in the
  // pulse cycle the requester has not yet had a chance to drop its req; its
  // still-high req must not be mistaken for a new request.
  always_comb begin
    st_elig   = stbuf_req & ~stbuf_done;
    ld_elig   = ld_req & ~flush & ~ld_valid;
    starved   = (starve_cnt >= LIMIT);
    store_win = (state == IDLE) & st_elig & (~ld_elig | starved);
    load_win  = (state == IDLE) & ld_elig & ~store_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_size   <= '0;
      bus_wdata  <= '0;
      stbuf_done <= 1'b0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
    end else begin
      // Completion pulses last exactly one cycle.
      stbuf_done <= 1'b0;
      ld_valid   <= 1'b0;

      case (state)
        IDLE: begin
          if (store_win) begin
            bus_req    <= 1'b1;
            bus_we     <= 1'b1;
            bus_addr   <= stbuf_addr;
            bus_size   <= stbuf_size;
            bus_wdata  <= stbuf_data;
            starve_cnt <= '0;
            state      <= ST_BUSY;
          end else if (load_win) begin
            // bus_wdata is left as-is; it is meaningless on a read.
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= ld_addr;
            bus_size <= ld_size;
            state    <= LD_BUSY;
            if (stbuf_req) begin
              if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end else if (!stbuf_req) begin
            starve_cnt <= '0;
          end
        end

        // Committed stores always complete; flush is irrelevant here.
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req    <= 1'b0;
            stbuf_done <= 1'b1;
            state      <= IDLE;
          end
        end

        LD_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            // A flush coinciding with the ack drops the data; ld_data keeps
            // its previous value.
            if (!flush) begin
              ld_valid <= 1'b1;
              ld_data  <= bus_rdata;
            end
          end else if (flush) begin
            // The bus read keeps running; only its response is dropped.
            state <= LD_DISCARD;
          end
        end

        LD_DISCARD: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_arbiter
//
// Directed vector table, hand-written multi-cycle sequences (starvation,
// asynchronous reset mid-transaction) and a randomized phase checked against
// a transaction-level reference model with an expected-read-data queue.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_lsu_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 2;
  localparam int LIM = 4;

  localparam logic [AW-1:0] ST_ADDR = 32'haaccbeef;
  localparam logic [SW-1:0] ST_SIZE = 2'd1;
  localparam logic [DW-1:0] ST_DATA = 32'h0000beef;
  localparam logic [AW-1:0] LD_ADDR = 32'h00000100;
  localparam logic [SW-1:0] LD_SIZE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          stbuf_req;
  logic [AW-1:0] stbuf_addr;
  logic [SW-1:0] stbuf_size;
  logic [DW-1:0] stbuf_data;
  logic          stbuf_done;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [SW-1:0] ld_size;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          flush;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [SW-1:0] bus_size;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [1:0]    state_dbg;

  lsu_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .stbuf_req(stbuf_req), .stbuf_addr(stbuf_addr), .stbuf_size(stbuf_size),
    .stbuf_data(stbuf_data), .stbuf_done(stbuf_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          stb;
    logic          ld;
    logic          fl;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          e_req;
    logic          e_we;
    logic          e_done;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic stb, input logic ld, input logic fl,
                              input logic ack, input logic [DW-1:0] rdata,
                              input logic e_req, input logic e_we, input logic e_done,
                              input logic e_valid, input logic [DW-1:0] e_data);
    vec_t v;
    v.stb = stb; v.ld = ld; v.fl = fl; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_done = e_done; v.e_valid = e_valid;
    v.e_data = e_data;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // m_kind: what the bus is doing: 0 nothing, 1 write, 2 read, 3 dropped read
  int            m_kind;
  int            m_starve;
  logic          e_req, e_we, e_done, e_valid;
  logic [AW-1:0] e_addr;
  logic [SW-1:0] e_size;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_data;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_kind = 0; m_starve = 0;
    e_req = 0; e_we = 0; e_done = 0; e_valid = 0;
    e_addr = '0; e_size = '0; e_wdata = '0; e_data = '0;
    exp_q.delete();
  endtask

  // Advances the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit was_done, was_valid, st_ok, ld_ok;
    was_done  = e_done;
    was_valid = e_valid;
    e_done    = 0;
    e_valid   = 0;
    if (m_kind == 0) begin
      st_ok = stbuf_req && !was_done;
      ld_ok = ld_req && !flush && !was_valid;
      if (st_ok && (!ld_ok || m_starve >= LIM)) begin
        m_kind = 1; e_req = 1; e_we = 1;
        e_addr = stbuf_addr; e_size = stbuf_size; e_wdata = stbuf_data;
        m_starve = 0;
      end else if (ld_ok) begin
        m_kind = 2; e_req = 1; e_we = 0;
        e_addr = ld_addr; e_size = ld_size;
        if (stbuf_req) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else m_starve = 0;
      end else if (!stbuf_req) begin
        m_starve = 0;
      end
    end else if (bus_ack) begin
      if (m_kind == 1) e_done = 1;
      if (m_kind == 2 && !flush) begin
        e_valid = 1;
        e_data  = bus_rdata;
        exp_q.push_back(bus_rdata);
      end
      m_kind = 0;
      e_req  = 0;
    end else if (m_kind == 2 && flush) begin
      m_kind = 3;
    end
  endtask

  task automatic check_model();
    chk("rnd bus_req", bus_req, e_req);
    if (e_req) begin
      chk("rnd bus_we", bus_we, e_we);
      chk("rnd bus_addr", bus_addr, e_addr);
      chk("rnd bus_size", bus_size, e_size);
      if (e_we) chk("rnd bus_wdata", bus_wdata, e_wdata);
    end
    chk("rnd stbuf_done", stbuf_done, e_done);
    chk("rnd ld_valid", ld_valid, e_valid);
    chk("rnd ld_data", ld_data, e_data);
    if (ld_valid) begin
      if (exp_q.size() == 0) chk("rnd ld_valid_unexpected", ld_valid, 1'b0);
      else chk("rnd ld_data_q", ld_data, exp_q.pop_front());
    end
  endtask

  task automatic new_store();
    stbuf_req  = 1'b1;
    stbuf_addr = $urandom;
    stbuf_size = SW'($urandom_range(0, 2));
    stbuf_data = $urandom;
  endtask

  task automatic new_load();
    ld_req  = 1'b1;
    ld_addr = $urandom;
    ld_size = SW'($urandom_range(0, 2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wait_left;

    rst = 1'b0;
    stbuf_req = 0; stbuf_addr = ST_ADDR; stbuf_size = ST_SIZE; stbuf_data = ST_DATA;
    ld_req = 0; ld_addr = LD_ADDR; ld_size = LD_SIZE;
    flush = 0; bus_ack = 0; bus_rdata = '0;

    // Vectors: stb ld fl ack rdata | req we done valid ld_data
    vt.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,32'h0));        // store wins
    vt.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,32'h0));        // wait 1
    vt.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,32'h0));        // wait 2
    vt.push_back(mk(1,0,0,1,32'h0,        0,0,1,0,32'h0));        // ack on 3rd
    vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,32'h0));        // done is one pulse
    vt.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,32'h0));        // load wins
    vt.push_back(mk(0,1,0,1,32'hdace1557, 0,0,0,1,32'hdace1557)); // zero-wait ack
    vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,32'hdace1557)); // ld_data holds
    vt.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,32'hdace1557)); // load wins
    vt.push_back(mk(0,1,1,0,32'h0,        1,0,0,0,32'hdace1557)); // flush, req held
    vt.push_back(mk(0,0,1,0,32'h0,        1,0,0,0,32'hdace1557)); // flush again ignored
    vt.push_back(mk(0,0,0,1,32'h12345678, 0,0,0,0,32'hdace1557)); // discarded ack
    vt.push_back(mk(0,0,0,1,32'h0,        0,0,0,0,32'hdace1557)); // stray ack ignored
    vt.push_back(mk(1,1,1,0,32'h0,        1,1,0,0,32'hdace1557)); // flush: store wins
    vt.push_back(mk(1,1,0,1,32'h0,        0,0,1,0,32'hdace1557)); // store done
    vt.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,32'hdace1557)); // load wins
    vt.push_back(mk(0,1,1,1,32'h00000055, 0,0,0,0,32'hdace1557)); // flush+ack: dropped
    vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,32'hdace1557)); // idle
    vt.push_back(mk(1,1,0,0,32'h0,        1,0,0,0,32'hdace1557)); // load priority
    vt.push_back(mk(1,1,0,1,32'ha5a5a5a5, 0,0,0,1,32'ha5a5a5a5)); // load done
    vt.push_back(mk(1,1,0,0,32'h0,        1,1,0,0,32'ha5a5a5a5)); // store, no bubble
    vt.push_back(mk(1,1,0,1,32'h0,        0,0,1,0,32'ha5a5a5a5)); // store done
    vt.push_back(mk(0,1,0,0,32'h0,        1,0,0,0,32'ha5a5a5a5)); // load, no bubble
    vt.push_back(mk(0,1,0,1,32'h0f0f0f0f, 0,0,0,1,32'h0f0f0f0f)); // load done
    vt.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,32'h0f0f0f0f)); // idle

    // Reset state
    step();
    step();
    chk("reset bus_req", bus_req, 1'b0);
    chk("reset bus_we", bus_we, 1'b0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_size", bus_size, 2'd0);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    chk("reset stbuf_done", stbuf_done, 1'b0);
    chk("reset ld_valid", ld_valid, 1'b0);
    chk("reset ld_data", ld_data, 32'h0);
    chk("reset state", state_dbg, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < vt.size(); i++) begin
      stbuf_req = vt[i].stb; ld_req = vt[i].ld; flush = vt[i].fl;
      bus_ack = vt[i].ack; bus_rdata = vt[i].rdata;
      step();
      chk($sformatf("vec%0d bus_req", i), bus_req, vt[i].e_req);
      if (vt[i].e_req) begin
        chk($sformatf("vec%0d bus_we", i), bus_we, vt[i].e_we);
        if (vt[i].e_we) begin
          chk($sformatf("vec%0d bus_addr", i), bus_addr, ST_ADDR);
          chk($sformatf("vec%0d bus_size", i), bus_size, ST_SIZE);
          chk($sformatf("vec%0d bus_wdata", i), bus_wdata, ST_DATA);
        end else begin
          chk($sformatf("vec%0d bus_addr", i), bus_addr, LD_ADDR);
          chk($sformatf("vec%0d bus_size", i), bus_size, LD_SIZE);
        end
      end
      chk($sformatf("vec%0d stbuf_done", i), stbuf_done, vt[i].e_done);
      chk($sformatf("vec%0d ld_valid", i), ld_valid, vt[i].e_valid);
      chk($sformatf("vec%0d ld_data", i), ld_data, vt[i].e_data);
    end
    chk("vec_end state", state_dbg, 2'd0);

    // Starvation: both held; each load is flushed as it is acked, so the
    // load requester never sees ld_valid and keeps winning until the limit.
    stbuf_req = 1; ld_req = 1;
    for (int k = 0; k < LIM; k++) begin
      flush = 0; bus_ack = 0;
      step();
      chk($sformatf("starve load%0d bus_req", k), bus_req, 1'b1);
      chk($sformatf("starve load%0d bus_we", k), bus_we, 1'b0);
      flush = 1; bus_ack = 1; bus_rdata = 32'hbad0bad0;
      step();
      chk($sformatf("starve load%0d end bus_req", k), bus_req, 1'b0);
      chk($sformatf("starve load%0d ld_valid", k), ld_valid, 1'b0);
      chk($sformatf("starve load%0d stbuf_done", k), stbuf_done, 1'b0);
    end
    flush = 0; bus_ack = 0;
    step();
    chk("starve forced store bus_req", bus_req, 1'b1);
    chk("starve forced store bus_we", bus_we, 1'b1);
    bus_ack = 1;
    step();
    chk("starve store done", stbuf_done, 1'b1);
    bus_ack = 0;
    step();
    chk("starve loads resume bus_we", bus_we, 1'b0);
    chk("starve loads resume bus_req", bus_req, 1'b1);
    chk("starve done once", stbuf_done, 1'b0);
    flush = 1; bus_ack = 1;
    step();
    flush = 0; bus_ack = 0;
    step();
    chk("starve cleared load wins bus_req", bus_req, 1'b1);
    chk("starve cleared load wins bus_we", bus_we, 1'b0);
    bus_ack = 1; bus_rdata = 32'h600dcafe;
    step();
    chk("starve final ld_valid", ld_valid, 1'b1);
    chk("starve final ld_data", ld_data, 32'h600dcafe);
    stbuf_req = 0; ld_req = 0; bus_ack = 0;
    step();

    // Asynchronous reset in the middle of a write
    stbuf_req = 1;
    step();
    chk("arst pre bus_req", bus_req, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst bus_req", bus_req, 1'b0);
    chk("arst stbuf_done", stbuf_done, 1'b0);
    chk("arst bus_we", bus_we, 1'b0);
    chk("arst bus_addr", bus_addr, 32'h0);
    chk("arst ld_data", ld_data, 32'h0);
    chk("arst state", state_dbg, 2'd0);
    stbuf_req = 0;
    @(negedge clk);
    rst = 1'b1;
    stbuf_req = 1;
    step();
    chk("arst new req bus_req", bus_req, 1'b1);
    bus_ack = 1;
    step();
    chk("arst new req done", stbuf_done, 1'b1);
    stbuf_req = 0; bus_ack = 0;
    step();
    chk("arst idle bus_req", bus_req, 1'b0);

    // Randomized phase against the reference model
    rst = 1'b0;
    #1;
    model_reset();
    stbuf_req = 0; ld_req = 0; flush = 0; bus_ack = 0; bus_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    wait_left = $urandom_range(0, 3);
    for (int c = 0; c < 3000; c++) begin
      if (e_done) begin
        if ($urandom_range(0, 1) == 1) new_store();
        else stbuf_req = 0;
      end else if (!stbuf_req && $urandom_range(0, 3) == 0) begin
        new_store();
      end
      // 'flush' still holds last cycle's value here
      if (e_valid || flush) begin
        if ($urandom_range(0, 1) == 1) new_load();
        else ld_req = 0;
      end else if (!ld_req && $urandom_range(0, 2) == 0) begin
        new_load();
      end
      flush = ($urandom_range(0, 9) == 0);
      bus_rdata = $urandom;
      if (e_req) begin
        if (wait_left == 0) begin
          bus_ack = 1;
          wait_left = $urandom_range(0, 3);
        end else begin
          bus_ack = 0;
          wait_left--;
        end
      end else begin
        bus_ack = ($urandom_range(0, 7) == 0);
      end
      model_step();
      step();
      check_model();
    end
    chk("rnd exp_q drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
